scr_frame_ctrl: RTL and testbench

Frame sequencer for the 1-dimensional scrambler core. It accepts a start pulse and a serial upstream stream. For each frame it loads the scrambler seed, passes HDR_LEN header beats unscrambled, then passes a configurable number of payload beats scrambled, then holds a fixed gap. It sits between the bit source and the scrambler core and drives the core's init, enable and data controls. It also keeps a per-frame seed that optionally advances.

---
 rtl/scr_pkg.sv | 32 +++
 rtl/scr_frame_ctrl_if.sv | 23 ++
 rtl/scr_seed_gen.sv | 32 +++
 rtl/scr_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_scr_frame_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scr_pkg.sv
// scr_pkg: types and helpers shared by the scrambler
// frame controller and the scrambler core.
package scr_pkg;

  localparam int SCR_WIDTH_DEF = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    HDR  = 3'd2,
    PAY  = 3'd3,
    GAP  = 3'd4
  } scr_ctrl_state_t;

  // An all-zero seed would lock the LFSR, so it maps to 1.
  function automatic logic [31:0] seed_fix(
    input logic [31:0] s
  );
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  // Increment modulo 2^w, skipping the all-zero value.
  function automatic logic [31:0] seed_adv(
    input logic [31:0] s,
    input int unsigned w
  );
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return seed_fix((s + 32'd1) & m);
  endfunction

endpackage

// File: rtl/scr_frame_ctrl_if.sv
// scr_frame_ctrl_if: upstream valid/ready beat stream
// feeding the scrambler frame controller.
interface scr_frame_ctrl_if #(
  parameter int DATA_WIDTH = 1
);

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/scr_seed_gen.sv
// scr_seed_gen: per-frame scrambler seed register with
// load at frame start and optional zero-skipping step.
module scr_seed_gen
  import scr_pkg::*;
#(
  parameter int SCR_WIDTH = SCR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 kill,
  input  logic                 load,
  input  logic [SCR_WIDTH-1:0] load_val,
  input  logic                 step,
  output logic [SCR_WIDTH-1:0] seed
);

  logic [SCR_WIDTH-1:0] seed_q;

  // seed: load wins; step only on completed frames
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      seed_q <= SCR_WIDTH'(1);
    end else if (load) begin
      seed_q <= SCR_WIDTH'(seed_fix(32'(load_val)));
    end else if (step) begin
      seed_q <= SCR_WIDTH'(seed_adv(32'(seed_q),
                                    SCR_WIDTH));
    end
  end

  assign seed = seed_q;

endmodule

// File: rtl/scr_frame_ctrl.sv
// scr_frame_ctrl: frame sequencer in front of the
// scrambler core (seed, header, payload, gap).
module scr_frame_ctrl
  import scr_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int SCR_WIDTH  = SCR_WIDTH_DEF,
  parameter int HDR_LEN    = 8,
  parameter int LEN_W      = 12,
  parameter int GAP_LEN    = 2
) (
  input  logic                  clk,
  input  logic                  kill,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SCR_WIDTH-1:0]  cfg_seed,
  input  logic                  cfg_seed_ld,
  input  logic                  cfg_seed_step,
  input  logic [LEN_W-1:0]      cfg_pay_len,
  scr_frame_ctrl_if.slave       up,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic                  core_data_in_en,
  output logic                  core_scr_en,
  output logic [SCR_WIDTH-1:0]  core_init_val,
  output logic                  core_init_val_en,
  output logic                  core_flush,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  localparam logic [LEN_W-1:0] CNT_ONE =
    LEN_W'(1);
  localparam logic [LEN_W-1:0] HDR_LAST =
    LEN_W'(HDR_LEN - 1);
  localparam logic [LEN_W-1:0] GAP_LAST =
    LEN_W'(GAP_LEN - 1);

  scr_ctrl_state_t state_q;
  scr_ctrl_state_t state_d;

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] pay_len_q;
  logic             step_q;
  logic             ready_q;
  logic             flush_q;
  logic [15:0]      fcnt_q;

  logic             beat;
  logic             start_ok;
  logic             abort_ok;
  logic             hdr_last;
  logic             pay_last;
  logic             gap_last;
  logic             done;
  logic             seed_load;
  logic             seed_step;
  logic [SCR_WIDTH-1:0] seed;

  assign beat     = up.s_valid & ready_q;
  assign start_ok = (state_q == IDLE) & start & ~abort;
  assign abort_ok = (state_q != IDLE) & abort;

  assign hdr_last = (cnt_q == HDR_LAST);
  assign pay_last = ((cnt_q + CNT_ONE) == pay_len_q);
  assign gap_last = (cnt_q == GAP_LAST);

  // Completion is the last GAP cycle unless aborted.
  assign done = (state_q == GAP) & gap_last & ~abort;

  // next-state decode; abort overrides every state
  always_comb begin
    state_d = state_q;
    if (abort_ok) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ok) state_d = SEED;
        end
        SEED: begin
          state_d = HDR;
        end
        HDR: begin
          if (beat && hdr_last) begin
            if (pay_len_q == '0) state_d = GAP;
            else                 state_d = PAY;
          end
        end
        PAY: begin
          if (beat && pay_last) state_d = GAP;
        end
        GAP: begin
          if (gap_last) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // state plus ready, decoded from the next state
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == HDR) | (state_d == PAY);
    end
  end

  // beat/gap counter, cleared on any state change
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (beat || (state_q == GAP)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // frame config is frozen at the accepted start
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      pay_len_q <= '0;
      step_q    <= 1'b0;
    end else if (start_ok) begin
      pay_len_q <= cfg_pay_len;
      step_q    <= cfg_seed_step;
    end
  end

  // one-cycle core clear following an abort
  always_ff @(posedge clk or posedge kill) begin
    if (kill) flush_q <= 1'b0;
    else      flush_q <= abort_ok;
  end

  // completed-frame counter, wraps naturally
  always_ff @(posedge clk or posedge kill) begin
    if (kill)      fcnt_q <= '0;
    else if (done) fcnt_q <= fcnt_q + 16'd1;
  end

  assign seed_load = start_ok & cfg_seed_ld;
  assign seed_step = done & step_q;

  scr_seed_gen #(
    .SCR_WIDTH (SCR_WIDTH)
  ) u_seed (
    .clk      (clk),
    .kill     (kill),
    .load     (seed_load),
    .load_val (cfg_seed),
    .step     (seed_step),
    .seed     (seed)
  );

  assign up.s_ready        = ready_q;
  assign core_data_in      = up.s_data;
  assign core_data_in_en   = beat;
  assign core_scr_en       = (state_q == PAY);
  assign core_init_val     = seed;
  assign core_init_val_en  = (state_q == SEED);
  assign core_flush        = flush_q;
  assign busy              = (state_q != IDLE);
  assign frame_done        = done;
  assign frame_cnt         = fcnt_q;

endmodule

// File: tb/tb_scr_frame_ctrl.sv
// tb_scr_frame_ctrl: scoreboard bench for the frame
// sequencer (beats, phases, seed, abort, kill).
module tb_scr_frame_ctrl;

  localparam int HDR = 8;
  localparam int GAP = 2;
  localparam int P_SEED = 1;
  localparam int P_HDR  = 2;
  localparam int P_PAY  = 3;
  localparam int P_GAP  = 4;

  logic        clk = 1'b0;
  logic        kill;
  logic        start;
  logic        abort;
  logic [6:0]  cfg_seed;
  logic        cfg_seed_ld;
  logic        cfg_seed_step;
  logic [11:0] cfg_pay_len;
  logic [0:0]  core_data_in;
  logic        core_data_in_en;
  logic        core_scr_en;
  logic [6:0]  core_init_val;
  logic        core_init_val_en;
  logic        core_flush;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  scr_frame_ctrl_if #(.DATA_WIDTH(1)) up_if ();

  scr_frame_ctrl dut (
    .clk              (clk),
    .kill             (kill),
    .start            (start),
    .abort            (abort),
    .cfg_seed         (cfg_seed),
    .cfg_seed_ld      (cfg_seed_ld),
    .cfg_seed_step    (cfg_seed_step),
    .cfg_pay_len      (cfg_pay_len),
    .up               (up_if),
    .core_data_in     (core_data_in),
    .core_data_in_en  (core_data_in_en),
    .core_scr_en      (core_scr_en),
    .core_init_val    (core_init_val),
    .core_init_val_en (core_init_val_en),
    .core_flush       (core_flush),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_cnt        (frame_cnt)
  );

  typedef struct packed {
    logic data;
    logic scr;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int checks     = 0;
  int failures   = 0;
  int beats_seen = 0;
  int exp_fcnt   = 0;

  always @(negedge clk) begin
    if (!kill && core_data_in_en) begin
      beats_seen++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL beat_extra got data=%b scr=%b want no beat",
                 core_data_in, core_scr_en);
      end else begin
        mon_e = sb.pop_front();
        if ({core_data_in, core_scr_en} !== {mon_e.data, mon_e.scr}) begin
          failures++;
          $display("FAIL beat got data=%b scr=%b want data=%b scr=%b",
                   core_data_in, core_scr_en, mon_e.data, mon_e.scr);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(
    input  logic [6:0] seed,
    input  logic       ld,
    input  logic       step,
    input  int         pay,
    input  bit         toggle,
    input  logic [6:0] exp_init,
    input  int         abort_after,
    output int         done_cyc
  );
    int ph;
    int cnt;
    bit fin;
    bit ab;
    bit acc;
    bit aborted;
    logic [4:0] obs;
    logic [4:0] exp_v;
    done_cyc = -1;
    aborted  = 0;
    tick;
    start         = 1'b1;
    abort         = 1'b0;
    cfg_seed      = seed;
    cfg_seed_ld   = ld;
    cfg_seed_step = step;
    cfg_pay_len   = 12'(pay);
    up_if.s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, up_if.s_ready, frame_cnt} !==
        {1'b0, 1'b0, 16'(exp_fcnt)}) begin
      failures++;
      $display("FAIL idle_before_start got busy=%b rdy=%b cnt=%0d want 0 0 %0d",
               busy, up_if.s_ready, frame_cnt, exp_fcnt);
    end
    ph  = P_SEED;
    cnt = 0;
    fin = 0;
    for (int c = 1; c <= 200 && !fin; c++) begin
      tick;
      start         = (c == 1);
      cfg_seed      = 7'($urandom);
      cfg_seed_ld   = 1'($urandom);
      cfg_seed_step = 1'($urandom);
      cfg_pay_len   = 12'($urandom);
      up_if.s_valid = toggle ? c[0] : 1'b1;
      up_if.s_data  = 1'($urandom);
      ab = (abort_after >= 0) && (ph == P_PAY) &&
           (cnt == abort_after);
      abort = ab;
      if (ab) start = 1'b1;
      acc = up_if.s_valid && (ph == P_HDR || ph == P_PAY);
      if (acc) sb.push_back(beat_t'{up_if.s_data, ph == P_PAY});
      @(negedge clk);
      exp_v = {ph == P_SEED, ph == P_PAY,
               ph == P_HDR || ph == P_PAY, 1'b1,
               ph == P_GAP && cnt == GAP - 1 && !ab};
      obs = {core_init_val_en, core_scr_en, up_if.s_ready,
             busy, frame_done};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL ctrl_cycle c=%0d got ien,scr,rdy,busy,done=%b want %b",
                 c, obs, exp_v);
      end
      if (ph == P_SEED) begin
        checks++;
        if (core_init_val !== exp_init) begin
          failures++;
          $display("FAIL init_val got %h want %h",
                   core_init_val, exp_init);
        end
      end
      if (ab) begin
        aborted = 1;
        fin = 1;
      end else begin
        case (ph)
          P_SEED: begin
            ph = P_HDR;
            cnt = 0;
          end
          P_HDR: begin
            if (acc) cnt++;
            if (cnt == HDR) begin
              ph = (pay == 0) ? P_GAP : P_PAY;
              cnt = 0;
            end
          end
          P_PAY: begin
            if (acc) cnt++;
            if (cnt == pay) begin
              ph = P_GAP;
              cnt = 0;
            end
          end
          default: begin
            cnt++;
            if (cnt == GAP) begin
              done_cyc = c;
              fin = 1;
              exp_fcnt++;
            end
          end
        endcase
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout got no end want end within 200 cycles");
    end
    if (aborted) begin
      tick;
      start = 1'b0;
      abort = 1'b0;
      up_if.s_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({core_flush, busy, up_if.s_ready, core_data_in_en,
           frame_cnt} !== {4'b1000, 16'(exp_fcnt)}) begin
        failures++;
        $display("FAIL abort_tail got fl,busy,rdy,en=%b cnt=%0d want 1000 %0d",
                 {core_flush, busy, up_if.s_ready, core_data_in_en},
                 frame_cnt, exp_fcnt);
      end
    end
  endtask

  task automatic test_reset;
    kill = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_seed = 7'h00;
    cfg_seed_ld = 1'b0;
    cfg_seed_step = 1'b0;
    cfg_pay_len = 12'd0;
    up_if.s_valid = 1'b1;
    up_if.s_data = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({up_if.s_ready, busy, frame_done, core_flush, core_scr_en,
         core_init_val_en, core_data_in_en, core_init_val,
         frame_cnt} !== {7'b0, 7'h01, 16'h0}) begin
      failures++;
      $display("FAIL reset_vals got flags=%b iv=%h cnt=%0d want 0 01 0",
               {up_if.s_ready, busy, frame_done, core_flush,
                core_scr_en, core_init_val_en, core_data_in_en},
               core_init_val, frame_cnt);
    end
    kill = 1'b0;
    up_if.s_valid = 1'b0;
  endtask

  task automatic test_basic;
    int d;
    int b0;
    b0 = beats_seen;
    run_frame(7'h5A, 1'b1, 1'b0, 4, 1'b0, 7'h5A, -1, d);
    checks++;
    if (d !== 15) begin
      failures++;
      $display("FAIL basic_len got %0d want 15", d);
    end
    checks++;
    if (beats_seen - b0 !== 12 || sb.size() != 0) begin
      failures++;
      $display("FAIL basic_beats got %0d left=%0d want 12 left=0",
               beats_seen - b0, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    int d;
    int b0;
    b0 = beats_seen;
    run_frame(7'h11, 1'b1, 1'b0, 3, 1'b0, 7'h11, -1, d);
    checks++;
    if (d !== 14) begin
      failures++;
      $display("FAIL b2b_len got %0d want 14", d);
    end
    run_frame(7'h5A, 1'b1, 1'b0, 4, 1'b1, 7'h5A, -1, d);
    checks++;
    if (d !== 27) begin
      failures++;
      $display("FAIL backpressure_len got %0d want 27", d);
    end
    checks++;
    if (beats_seen - b0 !== 23 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_beats got %0d left=%0d want 23 left=0",
               beats_seen - b0, sb.size());
    end
  endtask

  task automatic test_seed_step;
    int d;
    run_frame(7'h7F, 1'b1, 1'b1, 2, 1'b0, 7'h7F, -1, d);
    run_frame(7'h3C, 1'b0, 1'b1, 2, 1'b0, 7'h01, -1, d);
    run_frame(7'h3C, 1'b0, 1'b0, 1, 1'b0, 7'h02, -1, d);
    checks++;
    if (d !== 12) begin
      failures++;
      $display("FAIL seed_frame_len got %0d want 12", d);
    end
    run_frame(7'h00, 1'b1, 1'b0, 1, 1'b0, 7'h01, -1, d);
  endtask

  task automatic test_zero_pay;
    int d;
    run_frame(7'h5A, 1'b1, 1'b0, 0, 1'b0, 7'h5A, -1, d);
    checks++;
    if (d !== 11) begin
      failures++;
      $display("FAIL zero_pay_len got %0d want 11", d);
    end
  endtask

  task automatic test_abort;
    int d;
    run_frame(7'h33, 1'b1, 1'b1, 6, 1'b0, 7'h33, 2, d);
    checks++;
    if (d !== -1) begin
      failures++;
      $display("FAIL abort_done got cycle %0d want none", d);
    end
    tick;
    start = 1'b1;
    abort = 1'b1;
    cfg_seed = 7'h22;
    cfg_seed_ld = 1'b1;
    @(negedge clk);
    checks++;
    if ({core_flush, busy} !== 2'b00) begin
      failures++;
      $display("FAIL flush_pulse got fl,busy=%b want 00",
               {core_flush, busy});
    end
    tick;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_flush, busy, core_init_val_en} !== 3'b000) begin
      failures++;
      $display("FAIL start_abort_idle got fl,busy,ien=%b want 000",
               {core_flush, busy, core_init_val_en});
    end
    run_frame(7'h00, 1'b0, 1'b0, 1, 1'b0, 7'h33, -1, d);
  endtask

  task automatic test_kill;
    int d;
    tick;
    start = 1'b1;
    cfg_seed = 7'h44;
    cfg_seed_ld = 1'b1;
    cfg_seed_step = 1'b0;
    cfg_pay_len = 12'd4;
    up_if.s_valid = 1'b0;
    tick;
    start = 1'b0;
    tick;
    up_if.s_valid = 1'b1;
    up_if.s_data = 1'b1;
    sb.push_back(beat_t'{1'b1, 1'b0});
    tick;
    up_if.s_data = 1'b0;
    #1;
    checks++;
    if ({busy, up_if.s_ready} !== 2'b11) begin
      failures++;
      $display("FAIL pre_kill_hdr got busy,rdy=%b want 11",
               {busy, up_if.s_ready});
    end
    #1;
    kill = 1'b1;
    #1;
    checks++;
    if ({up_if.s_ready, busy, frame_done, core_flush, core_scr_en,
         core_init_val_en, core_data_in_en, core_init_val,
         frame_cnt} !== {7'b0, 7'h01, 16'h0}) begin
      failures++;
      $display("FAIL kill_async got flags=%b iv=%h cnt=%0d want 0 01 0",
               {up_if.s_ready, busy, frame_done, core_flush,
                core_scr_en, core_init_val_en, core_data_in_en},
               core_init_val, frame_cnt);
    end
    exp_fcnt = 0;
    @(negedge clk);
    kill = 1'b0;
    up_if.s_valid = 1'b0;
    run_frame(7'h55, 1'b0, 1'b0, 2, 1'b0, 7'h01, -1, d);
    checks++;
    if (d !== 13) begin
      failures++;
      $display("FAIL post_kill_len got %0d want 13", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_seed_step;
    test_zero_pay;
    test_abort;
    test_kill;
    tick;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
